// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling from a baud
// down-counter, registered one-cycle strobes for good bytes and framing errors.
module uart_rx #(
    parameter int BAUD_CLK_TICKS = 868,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial_data,
    output logic [7:0] o_rx_parallel_data,
    output logic       o_rx_data_valid,
    output logic       o_rx_frame_error,
    output logic       o_rx_busy
);

    localparam int CW = $clog2(BAUD_CLK_TICKS);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD_CLK_TICKS - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_CLK_TICKS / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt_q;
    logic                   tick;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic                   set_valid, set_ferr;

    // Input synchroniser; flops reset to the idle (high) line level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_serial_data};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign tick = (cnt_q == '0) && (state_q != IDLE);

    // Bit timer: half-bit load on start edge so later ticks land mid-bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                          cnt_q <= '0;
        else if (state_q == IDLE && !rx_s)  cnt_q <= HALF_RELOAD;
        else if (tick)                      cnt_q <= FULL_RELOAD;
        else                                cnt_q <= cnt_q - 1'b1;
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s) state_d = START;
            START: if (tick)  state_d = rx_s ? IDLE : DATA;
            DATA:  if (tick && idx_q == 3'd7) state_d = STOP;
            STOP:  if (tick)  state_d = rx_s ? IDLE : BRK;
            BRK:   if (rx_s)  state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // FSM outputs: strobe requests at the stop-bit sample
    always_comb begin
        set_valid = (state_q == STOP) && tick &&  rx_s;
        set_ferr  = (state_q == STOP) && tick && !rx_s;
    end

    assign o_rx_busy = (state_q != IDLE);

    // Shift register and bit index; LSB arrives first so shift right
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            if (state_q == START && tick) idx_q <= '0;
            if (state_q == DATA && tick) begin
                shift_q <= {rx_s, shift_q[7:1]};
                idx_q   <= idx_q + 3'd1;
            end
        end
    end

    // Output registers: byte updates together with its valid strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_parallel_data <= '0;
            o_rx_data_valid    <= 1'b0;
            o_rx_frame_error   <= 1'b0;
        end else begin
            o_rx_data_valid  <= set_valid;
            o_rx_frame_error <= set_ferr;
            if (set_valid) o_rx_parallel_data <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes queued as frames are driven,
// popped and compared on each valid strobe. Baud is scaled down for runtime.
module tb_uart_rx;

    localparam int BAUD = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, busy;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    logic [7:0] exp_q[$];
    logic       prev_strobe = 1'b0;
    logic       prev_valid  = 1'b0;

    uart_rx #(.BAUD_CLK_TICKS(BAUD), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_serial_data(rx),
        .o_rx_parallel_data(data), .o_rx_data_valid(valid),
        .o_rx_frame_error(ferr), .o_rx_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int blen, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        rx = 1'b0; cycles(blen);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; cycles(blen);
        end
        rx = stop_bit; cycles(blen);
        rx = 1'b1;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: sampled on the falling edge, away from DUT updates
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else                   check("data", data, exp_q.pop_front());
        end
        if (prev_valid) check("busy_after_valid", busy, 0);
        if (ferr) ferr_cnt++;
        if (valid || ferr) begin
            check("strobe_exclusive", valid & ferr, 0);
            check("strobe_back_to_back", prev_strobe, 0);
        end
        prev_strobe = valid | ferr;
        prev_valid  = valid;
    end

    initial begin
        int v0, f0;
        // 1: reset with line high
        cycles(3);
        rst = 1'b1; #2;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", ferr, 0);
        check("rst_busy", busy, 0);
        cycles(5);
        rst = 1'b0;
        cycles(20);
        check("idle_busy", busy, 0);

        // 2: single frame
        send_byte(8'hA5, BAUD, 1'b1);
        drain(4 * BAUD);
        check("a5_count", valid_cnt, 1);

        // 3: back-to-back frames with one stop bit
        send_byte(8'h00, BAUD, 1'b1);
        send_byte(8'hFF, BAUD, 1'b1);
        send_byte(8'h55, BAUD, 1'b1);
        drain(4 * BAUD);
        check("b2b_count", valid_cnt, 4);

        // 4: short low glitch is rejected at mid-start
        cycles(2 * BAUD);
        v0 = valid_cnt; f0 = ferr_cnt;
        rx = 1'b0; cycles(BAUD / 5);
        check("glitch_busy_high", busy, 1);
        rx = 1'b1; cycles(BAUD);
        check("glitch_busy_low", busy, 0);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_data", data, 8'h55);

        // 5: framing error then held break, then a good frame
        send_byte(8'h3C, BAUD, 1'b0);
        rx = 1'b0; cycles(20 * BAUD);
        check("break_ferr_count", ferr_cnt - f0, 1);
        check("break_no_valid", valid_cnt - v0, 0);
        check("break_data", data, 8'h55);
        check("break_busy", busy, 1);
        rx = 1'b1; cycles(2 * BAUD);
        check("break_exit_busy", busy, 0);
        send_byte(8'h81, BAUD, 1'b1);
        drain(4 * BAUD);
        check("after_break_ferr", ferr_cnt - f0, 1);

        // 6: reset during data bit 4 of 0x96
        v0 = valid_cnt;
        rx = 1'b0; cycles(BAUD);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h96 >> i) & 8'h01) != 0; cycles(BAUD);
        end
        rx = 1'b1; cycles(BAUD / 2);   // bit 4 of 0x96 is 1
        rst = 1'b1; #2;
        check("midrst_busy", busy, 0);
        check("midrst_data", data, 8'h00);
        cycles(5);
        rst = 1'b0;
        cycles(2 * BAUD);
        check("midrst_no_valid", valid_cnt - v0, 0);
        send_byte(8'h5A, BAUD, 1'b1);
        drain(4 * BAUD);
        check("midrst_5a_count", valid_cnt - v0, 1);

        // 7: +/-3% baud mismatch
        send_byte(8'hC3, BAUD * 103 / 100, 1'b1);
        send_byte(8'hC3, BAUD * 97 / 100, 1'b1);
        drain(4 * BAUD);
        check("total_valid", valid_cnt, 8);
        check("total_ferr", ferr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
